// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three-way arbiter for the common data bus (ALU, load, SLB).
// The granted payload is captured into a one-cycle broadcast register.
// The bus freezes on !rdy or stall, and flush clears the broadcast.
// Build option CDB_ARB_ROUND_ROBIN_EN selects rotating priority starting at ptr.
// Without it, priority is fixed: LD > ALU > SLB, and ptr stays 0.
`ifndef ROB_IDX_LN
`define ROB_IDX_LN 5
`endif

module cdb_arbiter #(
  parameter int ROB_BIT = `ROB_IDX_LN,
  parameter int NREQ    = 3
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               stall,
  input  logic               flush,
  input  logic               alu_valid,
  input  logic [ROB_BIT-1:0] alu_src,
  input  logic [31:0]        alu_val,
  input  logic               alu_tk,
  output logic               alu_ready,
  input  logic               ld_valid,
  input  logic [ROB_BIT-1:0] ld_src,
  input  logic [31:0]        ld_val,
  output logic               ld_ready,
  input  logic               slb_valid,
  input  logic [ROB_BIT-1:0] slb_src,
  input  logic [31:0]        slb_val,
  input  logic [31:0]        slb_addr,
  output logic               slb_ready,
  output logic               cdb_valid,
  output logic [1:0]         cdb_kind,
  output logic [ROB_BIT-1:0] cdb_src,
  output logic [31:0]        cdb_val,
  output logic               cdb_tk,
  output logic [31:0]        cdb_addr
);

  // Requester indices: 0 = ALU, 1 = LD, 2 = SLB
  logic [NREQ-1:0]  w_req;
  logic             w_open;
  logic             w_found;
  logic [1:0]       w_sel;
  logic             w_xfer;
  logic [1:0]       r_ptr;
  logic [15:0]      r_bcast_cnt;

  logic [ROB_BIT-1:0] w_src;
  logic [31:0]        w_val;
  logic               w_tk;
  logic [31:0]        w_addr;

  assign w_req  = {slb_valid, ld_valid, alu_valid};
  assign w_open = rdy && !stall && !flush && !rst;
  assign w_xfer = w_open && w_found;

  // Pick the winning requester: rotating search from ptr, or fixed LD > ALU > SLB
  always_comb begin : pick
    logic [2:0] idx;
    w_found = 1'b0;
    w_sel   = 2'd0;
    idx     = 3'd0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NREQ; k++) begin
      idx = 3'(r_ptr) + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!w_found && w_req[idx[1:0]]) begin
        w_found = 1'b1;
        w_sel   = idx[1:0];
      end
    end
`else
    if (w_req[1]) begin
      w_found = 1'b1;
      w_sel   = 2'd1;
    end else if (w_req[0]) begin
      w_found = 1'b1;
      w_sel   = 2'd0;
    end else if (w_req[2]) begin
      w_found = 1'b1;
      w_sel   = 2'd2;
    end
`endif
  end

  assign alu_ready = w_xfer && (w_sel == 2'd0);
  assign ld_ready  = w_xfer && (w_sel == 2'd1);
  assign slb_ready = w_xfer && (w_sel == 2'd2);

  // Payload mux for the selected requester; tk and addr are zero for non-owners
  always_comb begin
    w_src  = alu_src;
    w_val  = alu_val;
    w_tk   = 1'b0;
    w_addr = 32'd0;
    case (w_sel)
      2'd0: begin
        w_src = alu_src;
        w_val = alu_val;
        w_tk  = alu_tk;
      end
      2'd1: begin
        w_src = ld_src;
        w_val = ld_val;
      end
      default: begin
        w_src  = slb_src;
        w_val  = slb_val;
        w_addr = slb_addr;
      end
    endcase
  end

  // Broadcast register, priority pointer and debug transfer counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid   <= 1'b0;
      cdb_kind    <= 2'd0;
      cdb_src     <= '0;
      cdb_val     <= 32'd0;
      cdb_tk      <= 1'b0;
      cdb_addr    <= 32'd0;
      r_ptr       <= 2'd0;
      r_bcast_cnt <= 16'd0;
    end else if (flush) begin
      // Rollback wins over freeze: drop the in-flight broadcast only
      cdb_valid <= 1'b0;
    end else if (w_open) begin
      if (w_xfer) begin
        cdb_valid <= 1'b1;
        cdb_kind  <= w_sel;
        cdb_src   <= w_src;
        cdb_val   <= w_val;
        cdb_tk    <= w_tk;
        cdb_addr  <= w_addr;
`ifdef CDB_ARB_ROUND_ROBIN_EN
        r_ptr     <= (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
`else
        r_ptr     <= 2'd0;
`endif
        if (r_bcast_cnt != 16'hFFFF) r_bcast_cnt <= r_bcast_cnt + 16'd1;
      end else begin
        cdb_valid <= 1'b0;
        cdb_tk    <= 1'b0;
        cdb_addr  <= 32'd0;
      end
    end
    // rdy low or stall: everything holds so the ROB still sees the broadcast
  end

  // Sanity: at most one grant per cycle, ptr stays in range
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($countones({alu_ready, ld_ready, slb_ready}) <= 1);
      assert (r_ptr <= 2'd2);
`ifndef CDB_ARB_ROUND_ROBIN_EN
      assert (r_ptr == 2'd0);
`endif
      assert (r_bcast_cnt != 16'd0 || !cdb_valid || cdb_kind <= 2'd2);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios followed by randomized traffic.
// The randomized traffic is checked against a queue/array-level reference model.
module tb_cdb_arbiter;
  localparam int RB = 5;

  logic          clk = 1'b0;
  logic          rst, rdy, stall, flush;
  logic          alu_valid, alu_tk, ld_valid, slb_valid;
  logic [RB-1:0] alu_src, ld_src, slb_src;
  logic [31:0]   alu_val, ld_val, slb_val, slb_addr;
  logic          alu_ready, ld_ready, slb_ready;
  logic          cdb_valid, cdb_tk;
  logic [1:0]    cdb_kind;
  logic [RB-1:0] cdb_src;
  logic [31:0]   cdb_val, cdb_addr;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0]     rdy_vec;
  logic [72:0]    cdb_all;
  assign rdy_vec = {slb_ready, ld_ready, alu_ready};
  assign cdb_all = {cdb_valid, cdb_kind, cdb_src, cdb_val, cdb_tk, cdb_addr};

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_BIT(RB), .NREQ(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .flush(flush),
    .alu_valid(alu_valid), .alu_src(alu_src), .alu_val(alu_val), .alu_tk(alu_tk),
    .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_src(ld_src), .ld_val(ld_val), .ld_ready(ld_ready),
    .slb_valid(slb_valid), .slb_src(slb_src), .slb_val(slb_val), .slb_addr(slb_addr),
    .slb_ready(slb_ready),
    .cdb_valid(cdb_valid), .cdb_kind(cdb_kind), .cdb_src(cdb_src), .cdb_val(cdb_val),
    .cdb_tk(cdb_tk), .cdb_addr(cdb_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; stall = 1'b0; flush = 1'b0;
    alu_valid = 1'b0; ld_valid = 1'b0; slb_valid = 1'b0;
    alu_src = '0; ld_src = '0; slb_src = '0;
    alu_val = '0; ld_val = '0; slb_val = '0; slb_addr = '0; alu_tk = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    alu_valid = 1'b1; ld_valid = 1'b1; slb_valid = 1'b1;
    alu_src = 5'd7; alu_val = 32'hAAAA; alu_tk = 1'b1;
    ld_src = 5'd8; ld_val = 32'hBBBB;
    slb_src = 5'd9; slb_val = 32'hCCCC; slb_addr = 32'hDDDD;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (rdy_vec !== 3'b000) begin
        n_err++; $display("FAIL reset_ready: got %b want 000", rdy_vec);
      end
      tick();
      n_cmp++;
      if (cdb_all !== 73'd0) begin
        n_err++; $display("FAIL reset_cdb: got %h want 0", cdb_all);
      end
    end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_latency();
    idle();
    alu_valid = 1'b1; alu_src = 5'd5; alu_val = 32'h1234; alu_tk = 1'b1;
    #1;
    n_cmp++;
    if (rdy_vec !== 3'b001) begin
      n_err++; $display("FAIL latency_ready: got %b want 001", rdy_vec);
    end
    tick();
    idle();
    n_cmp++;
    if (cdb_all !== {1'b1, 2'd0, 5'd5, 32'h1234, 1'b1, 32'd0}) begin
      n_err++; $display("FAIL latency_bcast: got %h", cdb_all);
    end
    tick();
    n_cmp++;
    if (cdb_valid !== 1'b0 || cdb_tk !== 1'b0 || cdb_addr !== 32'd0) begin
      n_err++; $display("FAIL latency_clear: valid=%b tk=%b addr=%h want 0", cdb_valid, cdb_tk, cdb_addr);
    end
  endtask

  task automatic test_priority();
    logic [2:0] want;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alu_valid = 1'b1; ld_valid = 1'b1; slb_valid = 1'b1;
    alu_src = 5'd1; ld_src = 5'd2; slb_src = 5'd3;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      want = 3'b001 << (k % 3);
      #1;
      n_cmp++;
      if (rdy_vec !== want) begin
        n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, rdy_vec, want);
      end
      tick();
      n_cmp++;
      if (cdb_valid !== 1'b1 || cdb_kind !== 2'(k % 3) || cdb_src !== 5'(k % 3 + 1)) begin
        n_err++; $display("FAIL rr_kind%0d: got v=%b kind=%0d src=%0d want kind=%0d", k, cdb_valid, cdb_kind, cdb_src, k % 3);
      end
    end
`else
    want = 3'b010;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (rdy_vec !== want) begin
        n_err++; $display("FAIL fixed_grant%0d: got %b want %b", k, rdy_vec, want);
      end
      tick();
      n_cmp++;
      if (cdb_valid !== 1'b1 || cdb_kind !== 2'd1 || cdb_src !== 5'd2) begin
        n_err++; $display("FAIL fixed_kind%0d: got v=%b kind=%0d src=%0d want kind=1", k, cdb_valid, cdb_kind, cdb_src);
      end
    end
`endif
    idle();
    tick();
  endtask

  task automatic test_stall();
    logic [2:0] want;
    logic [1:0] want_kind;
    idle();
    slb_valid = 1'b1; slb_src = 5'd4; slb_val = 32'h55; slb_addr = 32'h100;
    #1;
    n_cmp++;
    if (rdy_vec !== 3'b100) begin
      n_err++; $display("FAIL stall_pre_grant: got %b want 100", rdy_vec);
    end
    tick();
    idle();
    stall = 1'b1;
    alu_valid = 1'b1; alu_src = 5'd10; alu_val = 32'h77;
    ld_valid = 1'b1; ld_src = 5'd11; ld_val = 32'h88;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (rdy_vec !== 3'b000) begin
        n_err++; $display("FAIL stall_ready%0d: got %b want 000", c, rdy_vec);
      end
      tick();
      n_cmp++;
      if (cdb_all !== {1'b1, 2'd2, 5'd4, 32'h55, 1'b0, 32'h100}) begin
        n_err++; $display("FAIL stall_hold%0d: got %h", c, cdb_all);
      end
    end
    stall = 1'b0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    want = 3'b001; want_kind = 2'd0;
`else
    want = 3'b010; want_kind = 2'd1;
`endif
    #1;
    n_cmp++;
    if (rdy_vec !== want) begin
      n_err++; $display("FAIL stall_release_grant: got %b want %b", rdy_vec, want);
    end
    tick();
    n_cmp++;
    if ({cdb_valid, cdb_kind, cdb_addr} !== {1'b1, want_kind, 32'd0}) begin
      n_err++; $display("FAIL stall_replace: got v=%b kind=%0d addr=%h want kind=%0d", cdb_valid, cdb_kind, cdb_addr, want_kind);
    end
    idle();
    tick();
    n_cmp++;
    if (cdb_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_clear: got %b want 0", cdb_valid);
    end
  endtask

  task automatic test_flush();
    logic [2:0] want;
    idle();
    ld_valid = 1'b1; ld_src = 5'd12; ld_val = 32'h99;
    tick();
    n_cmp++;
    if (cdb_valid !== 1'b1 || cdb_kind !== 2'd1) begin
      n_err++; $display("FAIL flush_setup: got v=%b kind=%0d want v=1 kind=1", cdb_valid, cdb_kind);
    end
    stall = 1'b1; flush = 1'b1;
    #1;
    n_cmp++;
    if (rdy_vec !== 3'b000) begin
      n_err++; $display("FAIL flush_ready: got %b want 000", rdy_vec);
    end
    tick();
    n_cmp++;
    if (cdb_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_valid: got %b want 0", cdb_valid);
    end
    stall = 1'b0; flush = 1'b0;
    alu_valid = 1'b1; slb_valid = 1'b1;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    want = 3'b100;
`else
    want = 3'b010;
`endif
    #1;
    n_cmp++;
    if (rdy_vec !== want) begin
      n_err++; $display("FAIL flush_ptr_grant: got %b want %b", rdy_vec, want);
    end
    tick();
    idle();
    tick();
  endtask

  // Reference: each requester is an "outstanding transaction" slot; the bus
  // picks by the priority list and the model keeps what the ROB should see.
  task automatic test_random(input int ncyc);
    bit            pend[3];
    logic [RB-1:0] psrc[3];
    logic [31:0]   pval[3];
    bit            ptk;
    logic [31:0]   paddr;
    int            mptr, g, wait_c[3], order[3];
    bit            open;
    logic [2:0]    exp_rdy;
    logic          mv, mtk;
    logic [1:0]    mk;
    logic [RB-1:0] msrc;
    logic [31:0]   mval, maddr;
    mptr = 0; ptk = 0; paddr = 0;
    mv = 0; mtk = 0; mk = 0; msrc = 0; mval = 0; maddr = 0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 0; psrc[i] = 0; pval[i] = 0; wait_c[i] = 0;
    end
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      for (int i = 0; i < 3; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1; psrc[i] = RB'($urandom); pval[i] = $urandom;
          if (i == 0) ptk = 1'($urandom);
          if (i == 2) paddr = $urandom;
        end
      alu_valid = pend[0]; alu_src = psrc[0]; alu_val = pval[0]; alu_tk = ptk;
      ld_valid = pend[1]; ld_src = psrc[1]; ld_val = pval[1];
      slb_valid = pend[2]; slb_src = psrc[2]; slb_val = pval[2]; slb_addr = paddr;
      rst   = (cyc == 0) || ($urandom_range(0, 39) == 0);
      rdy   = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 9) == 0);
      open  = rdy && !stall && !flush && !rst;
`ifdef CDB_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < 3; k++) order[k] = (mptr + k) % 3;
`else
      order[0] = 1; order[1] = 0; order[2] = 2;
`endif
      g = -1;
      if (open)
        for (int k = 0; k < 3; k++)
          if (g < 0 && pend[order[k]]) g = order[k];
      exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
      #1;
      n_cmp++;
      if (rdy_vec !== exp_rdy) begin
        n_err++; $display("FAIL rand_ready c%0d: got %b want %b", cyc, rdy_vec, exp_rdy);
      end
`ifdef CDB_ARB_ROUND_ROBIN_EN
      for (int i = 0; i < 3; i++) begin
        if (rst || g == i) wait_c[i] = 0;
        else if (open && pend[i]) wait_c[i]++;
        if (wait_c[i] > 2) begin
          n_cmp++; n_err++;
          $display("FAIL rand_starve c%0d: req %0d waited %0d open cycles want <=2", cyc, i, wait_c[i]);
          wait_c[i] = 0;
        end
      end
`endif
      if (rst) begin
        mv = 0; mk = 0; msrc = 0; mval = 0; mtk = 0; maddr = 0; mptr = 0;
      end else if (flush) begin
        mv = 0;
      end else if (open) begin
        if (g >= 0) begin
          mv = 1; mk = 2'(g); msrc = psrc[g]; mval = pval[g];
          mtk = (g == 0) ? ptk : 1'b0;
          maddr = (g == 2) ? paddr : 32'd0;
          pend[g] = 0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
          mptr = (g + 1) % 3;
`endif
        end else begin
          mv = 0; mtk = 0; maddr = 0;
        end
      end
      tick();
      n_cmp++;
      if (cdb_all !== {mv, mk, msrc, mval, mtk, maddr}) begin
        n_err++; $display("FAIL rand_bcast c%0d: got %h want %h", cyc, cdb_all, {mv, mk, msrc, mval, mtk, maddr});
      end
    end
    idle();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_latency();
    test_priority();
    test_stall();
    test_flush();
    test_random(2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
